// File: rtl/image_op_scheduler_if.sv
// Requester and engine signal bundle for the frame-level operation scheduler.
// The scheduler connects through the slave modport; requesters and the engine use master.
interface image_op_scheduler_if #(
  parameter int unsigned NREQ = 4
) ();

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_value;
  logic [NREQ-1:0]   req_sign;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              ack_ok;

  logic              eng_start;
  logic              eng_abort;
  logic [1:0]        eng_op;
  logic [7:0]        eng_value;
  logic              eng_sign;
  logic              eng_hsync;
  logic              eng_done;

  modport master (
    output req, req_op, req_value, req_sign, eng_hsync, eng_done,
    input  gnt, ack, ack_ok, eng_start, eng_abort, eng_op, eng_value, eng_sign
  );

  modport slave (
    input  req, req_op, req_value, req_sign, eng_hsync, eng_done,
    output gnt, ack, ack_ok, eng_start, eng_abort, eng_op, eng_value, eng_sign
  );

endinterface

// File: rtl/image_op_scheduler.sv
// Frame-level controller: round-robin arbitration of per-frame operation requests,
// engine configuration/start, and per-frame supervision by pixel count and watchdog.
module image_op_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned WIDTH      = 768,
  parameter int unsigned HEIGHT     = 512,
  parameter int unsigned TIMEOUT    = 524288,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  image_op_scheduler_if.slave  bus,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_len,
  input  logic                 err_clr,
  output logic [15:0]          frame_count
);

  localparam int unsigned IW   = $clog2(NREQ);
  localparam int unsigned PW   = 20;
  localparam int unsigned WW   = $clog2(TIMEOUT + 1);
  localparam int unsigned GW   = $clog2(GAP_CYCLES + 1);
  localparam int unsigned NPIX = WIDTH * HEIGHT;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CFG,
    START,
    RUN,
    GAP
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [PW-1:0]   pix_cnt;
  logic [WW-1:0]   wd_cnt;
  logic [GW-1:0]   gap_cnt;

  logic [1:0]      op_a    [NREQ];
  logic [7:0]      value_a [NREQ];
  logic            sign_a  [NREQ];

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic [PW-1:0]   pix_nxt;
  logic            frame_ok;
  logic            wd_expired;
  logic [IW-1:0]   next_ptr;

  // Per-requester views of the packed configuration buses.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g]    = bus.req_op[2*g +: 2];
    assign value_a[g] = bus.req_value[8*g +: 8];
    assign sign_a[g]  = bus.req_sign[g];
  end

  // Round-robin search starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(rr_ptr) + i) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // The pixel seen on the done cycle counts toward the frame length.
  assign pix_nxt    = pix_cnt + PW'(bus.eng_hsync);
  assign frame_ok   = (pix_nxt == PW'(NPIX));
  assign wd_expired = (wd_cnt == WW'(TIMEOUT - 1));
  assign next_ptr   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      pix_cnt       <= '0;
      wd_cnt        <= '0;
      gap_cnt       <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      err_len       <= 1'b0;
      frame_count   <= '0;
      bus.gnt       <= '0;
      bus.ack       <= '0;
      bus.ack_ok    <= 1'b0;
      bus.eng_start <= 1'b0;
      bus.eng_abort <= 1'b0;
      bus.eng_op    <= '0;
      bus.eng_value <= '0;
      bus.eng_sign  <= 1'b0;
    end else begin
      bus.ack       <= '0;
      bus.ack_ok    <= 1'b0;
      bus.eng_start <= 1'b0;
      bus.eng_abort <= 1'b0;

      // Clear first so that a set event later in this cycle takes priority.
      if (err_clr) begin
        err_timeout <= 1'b0;
        err_len     <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|bus.req) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end

        ARB: begin
          if (found) begin
            owner         <= pick;
            bus.gnt       <= NREQ'(1) << pick;
            bus.eng_op    <= op_a[pick];
            bus.eng_value <= value_a[pick];
            bus.eng_sign  <= sign_a[pick];
            state         <= CFG;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        CFG: begin
          bus.eng_start <= 1'b1;
          state         <= START;
        end

        START: begin
          pix_cnt <= '0;
          wd_cnt  <= '0;
          state   <= RUN;
        end

        RUN: begin
          pix_cnt <= pix_nxt;
          wd_cnt  <= wd_cnt + WW'(1);
          if (bus.eng_done) begin
            bus.ack    <= bus.gnt;
            bus.ack_ok <= frame_ok;
            bus.gnt    <= '0;
            if (frame_ok) begin
              frame_count <= frame_count + 16'd1;
            end else begin
              err_len <= 1'b1;
            end
            rr_ptr  <= next_ptr;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (wd_expired) begin
            bus.eng_abort <= 1'b1;
            bus.ack       <= bus.gnt;
            bus.ack_ok    <= 1'b0;
            bus.gnt       <= '0;
            err_timeout   <= 1'b1;
            rr_ptr        <= next_ptr;
            gap_cnt       <= '0;
            state         <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_op_scheduler.sv
// Directed and randomized frames checked against a queue-free round-robin and
// outcome model of the scheduler (small image, short watchdog).
module tb_image_op_scheduler;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 4;
  localparam int HEIGHT  = 2;
  localparam int NPIX    = WIDTH * HEIGHT;
  localparam int TIMEOUT = 20;
  localparam int GAP     = 4;

  logic        HCLK;
  logic        HRESET;
  logic        busy;
  logic        err_timeout;
  logic        err_len;
  logic        err_clr;
  logic [15:0] frame_count;

  image_op_scheduler_if #(.NREQ(NREQ)) bus ();

  image_op_scheduler #(
    .NREQ(NREQ), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus), .busy(busy),
    .err_timeout(err_timeout), .err_len(err_len), .err_clr(err_clr),
    .frame_count(frame_count)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_ack = -1;

  // Reference model state
  logic [3:0]  m_req;
  logic [1:0]  m_op   [4];
  logic [7:0]  m_val  [4];
  logic        m_sign [4];
  int unsigned m_ptr;
  int          m_fc;
  bit          m_elen, m_eto;

  // Per-frame stimulus knobs
  int g_lead;
  bit g_dense, g_drop, g_keep, g_clr, g_newval;

  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned pick_rr(input logic [3:0] r, input int unsigned p);
    for (int k = 0; k < 4; k++) begin
      int unsigned idx;
      idx = (p + 32'(k)) % 4;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic drive_req();
    bus.req       = m_req;
    bus.req_op    = {m_op[3], m_op[2], m_op[1], m_op[0]};
    bus.req_value = {m_val[3], m_val[2], m_val[1], m_val[0]};
    bus.req_sign  = {m_sign[3], m_sign[2], m_sign[1], m_sign[0]};
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < 4; i++) begin
      m_op[i]   = 2'($urandom);
      m_val[i]  = 8'($urandom);
      m_sign[i] = 1'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 0);
    check({tag, "_ack"}, 32'(bus.ack), 0);
    check({tag, "_ackok"}, 32'(bus.ack_ok), 0);
    check({tag, "_start"}, 32'(bus.eng_start), 0);
    check({tag, "_abort"}, 32'(bus.eng_abort), 0);
    check({tag, "_cfg"}, 32'({bus.eng_op, bus.eng_value, bus.eng_sign}), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_errs"}, 32'({err_timeout, err_len}), 0);
    check({tag, "_fc"}, 32'(frame_count), 0);
  endtask

  // One complete frame: grant, config, engine pixels, outcome, ack.
  task automatic do_frame(input int npix, input bit do_done);
    int unsigned own;
    int w, pix, run, start_cyc;
    bit hs, dn, tmo, clean;
    logic [1:0] x_op;
    logic [7:0] x_val;
    logic       x_sign;

    own = pick_rr(m_req, m_ptr);
    w = 0;
    while (bus.gnt === '0 && w < 40) begin tick(); w++; end
    check("gnt", 32'(bus.gnt), 32'(4'b0001 << own));
    if (last_ack >= 0) check("gap_to_gnt", 32'(cyc - last_ack), 32'(GAP + 2));
    x_op = m_op[own]; x_val = m_val[own]; x_sign = m_sign[own];

    w = 0;
    while (bus.eng_start !== 1'b1 && w < 10) begin tick(); w++; end
    check("eng_start", 32'(bus.eng_start), 1);
    check("eng_op", 32'(bus.eng_op), 32'(x_op));
    check("eng_value", 32'(bus.eng_value), 32'(x_val));
    check("eng_sign", 32'(bus.eng_sign), 32'(x_sign));
    start_cyc = cyc;

    // A stray pixel strobe during START must not count.
    bus.eng_hsync = 1'($urandom);
    tick();
    bus.eng_hsync = 1'b0;
    if (g_newval) begin m_val[own] = 8'd200; drive_req(); end
    if (g_drop)   begin m_req[own] = 1'b0;   drive_req(); end

    pix = 0; run = 0;
    while (pix < npix) begin
      hs = (run >= g_lead) && (g_dense || ($urandom % 4 != 0) || run >= 10);
      if (hs) pix++;
      dn = do_done && hs && (pix == npix);
      bus.eng_hsync = hs;
      bus.eng_done  = dn;
      err_clr       = g_clr && dn;
      tick();
      run++;
    end
    bus.eng_hsync = 1'b0; bus.eng_done = 1'b0; err_clr = 1'b0;

    w = 0;
    while (bus.ack === '0 && w < 40) begin tick(); w++; end

    tmo = !do_done;
    if (g_clr && do_done) begin m_eto = 0; m_elen = 0; end
    clean = !tmo && (npix == NPIX);
    if (tmo) m_eto = 1;
    else if (clean) m_fc = (m_fc + 1) % 65536;
    else m_elen = 1;

    if (tmo) check("abort_latency", 32'(cyc - start_cyc), 32'(TIMEOUT + 1));
    else     check("ack_latency", 32'(cyc - start_cyc), 32'(run + 1));
    check("ack", 32'(bus.ack), 32'(4'b0001 << own));
    check("ack_ok", 32'(bus.ack_ok), 32'(clean));
    check("eng_abort", 32'(bus.eng_abort), 32'(tmo));
    check("gnt_cleared", 32'(bus.gnt), 0);
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("err_len", 32'(err_len), 32'(m_elen));
    check("err_timeout", 32'(err_timeout), 32'(m_eto));
    check("cfg_held", 32'({bus.eng_op, bus.eng_value, bus.eng_sign}), 32'({x_op, x_val, x_sign}));
    check("busy", 32'(busy), 1);

    m_ptr = (own + 1) % 4;
    last_ack = cyc;
    if (!g_keep) m_req[own] = 1'b0;
    drive_req();

    // Engine strobes outside RUN are ignored.
    bus.eng_done = 1'b1; bus.eng_hsync = 1'b1;
    tick();
    bus.eng_done = 1'b0; bus.eng_hsync = 1'b0;
    check("ack_one_cycle", 32'({bus.ack, bus.eng_abort}), 0);
  endtask

  initial begin
    int w;
    HRESET = 1'b1; err_clr = 1'b0;
    bus.eng_hsync = 1'b0; bus.eng_done = 1'b0;
    m_req = '0; rand_cfg(); drive_req();
    m_ptr = 0; m_fc = 0; m_elen = 0; m_eto = 0;
    g_lead = 0; g_dense = 0; g_drop = 0; g_keep = 0; g_clr = 0; g_newval = 0;
    repeat (3) tick();
    check_all_zero("reset");
    HRESET = 1'b0;

    // Single clean frame with latency check.
    m_op[0] = 2'd1; m_val[0] = 8'd100; m_sign[0] = 1'b1; m_req = 4'b0001;
    drive_req();
    tick(); check("lat_gnt_early", 32'(bus.gnt), 0);
    tick(); check("lat_gnt", 32'(bus.gnt), 32'(4'b0001));
    tick(); check("lat_start", 32'(bus.eng_start), 1);
    do_frame(NPIX, 1);

    // All requesters held: rotation and inter-frame gap.
    rand_cfg(); m_req = 4'b1111; drive_req(); g_keep = 1;
    for (int f = 0; f < 5; f++) begin
      g_lead = $urandom_range(0, 2);
      do_frame(NPIX, 1);
    end
    g_keep = 0;

    // Short frame with a same-cycle clear, then a clear on its own.
    m_req = 4'b0100; drive_req(); g_clr = 1;
    do_frame(NPIX - 1, 1);
    g_clr = 0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    m_elen = 0; m_eto = 0;
    check("err_len_clr", 32'(err_len), 0);
    m_req = 4'b1000; drive_req();
    do_frame(NPIX + 1, 1);

    // Watchdog abort, then the next request is still served.
    m_req = 4'b0010; drive_req();
    do_frame(3, 0);
    m_req = 4'b0001; drive_req();
    do_frame(NPIX, 1);

    // Done lands on the same cycle as the watchdog limit.
    m_req = 4'b0100; drive_req(); g_lead = 12; g_dense = 1;
    do_frame(NPIX, 1);
    g_lead = 0; g_dense = 0;

    // Owner changes its value mid-frame.
    m_val[3] = 8'd50; m_req = 4'b1000; drive_req(); g_newval = 1;
    do_frame(NPIX, 1);
    g_newval = 0;

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      int sel;
      rand_cfg();
      m_req = 4'($urandom_range(1, 15)); drive_req();
      g_drop = ($urandom % 3 == 0);
      g_lead = $urandom_range(0, 2);
      sel = $urandom_range(0, 4);
      do_frame((sel == 0) ? NPIX - 1 : (sel == 1) ? NPIX + 1 : NPIX, 1);
    end
    g_drop = 0;

    // Reset in the middle of RUN.
    m_req = 4'b0010; drive_req(); last_ack = -1;
    w = 0;
    while (bus.eng_start !== 1'b1 && w < 40) begin tick(); w++; end
    check("pre_reset_start", 32'(bus.eng_start), 1);
    bus.eng_hsync = 1'b1;
    repeat (3) tick();
    bus.eng_hsync = 1'b0;
    HRESET = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    m_req = 4'b0100; drive_req();
    repeat (2) tick();
    check("reset_held_busy", 32'({busy, bus.ack}), 0);
    HRESET = 1'b0;
    m_ptr = 0; m_fc = 0; m_elen = 0; m_eto = 0;
    do_frame(NPIX, 1);

    // Return to idle.
    m_req = '0; drive_req();
    repeat (10) tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_gnt", 32'(bus.gnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
